// File: rtl/crp16_run_control_pkg.sv
// Shared definitions for the crp16 run/step/breakpoint controller.
// The state encodings are also exposed as guarded macros so board-level
// code and display decoders can name them without importing the package.

`ifndef CRP16_RUN_CONTROL_DEFS_VH
`define CRP16_RUN_CONTROL_DEFS_VH
`define CRP16_RC_HALT  2'd0
`define CRP16_RC_RUN   2'd1
`define CRP16_RC_STEP  2'd2
`define CRP16_RC_BREAK 2'd3
`endif

package crp16_run_control_pkg;

    // Controller states; the numeric values are what the state output shows
    typedef enum logic [1:0] {
        RC_HALT  = `CRP16_RC_HALT,
        RC_RUN   = `CRP16_RC_RUN,
        RC_STEP  = `CRP16_RC_STEP,
        RC_BREAK = `CRP16_RC_BREAK
    } rcState_e;

    localparam int RC_TICK_W = 16;

    // Run-rate reload: each rate step divides the base period by four
    function automatic logic [31:0] rcReload(input logic [31:0] basePeriod,
                                             input logic [1:0]  rateSel);
        return basePeriod >> {rateSel, 1'b0};
    endfunction

endpackage

// File: rtl/crp16_debounce.sv
// Key debouncer: 2-FF synchronizer, stability counter and a registered
// one-cycle pulse on each rising edge of the debounced level.
// Reusable for any raw active-high push button.

module crp16_debounce #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_i,
    output logic press_o
);

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_d;
    logic        levelPrev_q;
    logic        press_q;
    logic [31:0] count_q;
    logic [31:0] count_d;

    // The debounced level only follows the synchronized key once it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement in
    // between restarts the count from zero.
    always_comb begin
        count_d = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (count_q == DEBOUNCE_CYCLES - 32'd1) begin
                level_d = sync2_q;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    // Synchronizer, counter and level registers, plus the edge history that
    // turns a debounced rise into a single registered press pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            levelPrev_q <= 1'b0;
            press_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            sync1_q     <= key_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            count_q     <= count_d;
            levelPrev_q <= level_q;
            press_q     <= level_q & ~levelPrev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/crp16_run_control.sv
// Run/step/breakpoint controller for the crp16 datapath. Issues a single
// cycle cpu_en pulse per datapath step, either free-running at a selectable
// rate, one at a time from the step key, or stopping at a PC breakpoint.

module crp16_run_control
    import crp16_run_control_pkg::*;
#(
    parameter logic [31:0] BASE_PERIOD     = 32'd25000000,
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500000,
    parameter int unsigned PC_W            = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run_sw,
    input  logic            step_key,
    input  logic [1:0]      rate_sel,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc_view,
    output logic            cpu_en,
    output logic            halted,
    output logic            at_break,
    output logic [1:0]      state,
    output logic [15:0]     tick_count
);

    logic                 runSync1_q;
    logic                 runSync2_q;
    logic                 runPrev_q;
    logic                 runRise_q;
    logic                 runFall_q;
    logic                 stepPress;
    rcState_e             state_q;
    logic [31:0]          divider_q;
    logic                 tickDue_q;
    logic                 skip_q;
    logic                 cpuEn_q;
    logic [RC_TICK_W-1:0] tickCount_q;
    logic [31:0]          reloadMinus1;
    logic                 bpHit;

    crp16_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) stepDebounce (
        .clock  (clock),
        .reset  (reset),
        .key_i  (step_key),
        .press_o(stepPress)
    );

    // The run switch is a clean level, so it only needs synchronizing and
    // registered rise/fall detection. History resets to 0 so a switch held
    // high through reset still produces a rise afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            runSync1_q <= 1'b0;
            runSync2_q <= 1'b0;
            runPrev_q  <= 1'b0;
            runRise_q  <= 1'b0;
            runFall_q  <= 1'b0;
        end else begin
            runSync1_q <= run_sw;
            runSync2_q <= runSync1_q;
            runPrev_q  <= runSync2_q;
            runRise_q  <= runSync2_q & ~runPrev_q;
            runFall_q  <= ~runSync2_q & runPrev_q;
        end
    end

    assign reloadMinus1 = rcReload(BASE_PERIOD, rate_sel) - 32'd1;
    assign bpHit        = bp_en && (pc_view == bp_addr) && !skip_q;

    // Main controller: state, rate divider, pending tick, breakpoint skip
    // flag and the registered cpu_en pulse. A due tick is acted on one cycle
    // after the divider reload, so a run fall seen in that cycle wins and
    // no pulse is issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RC_HALT;
            divider_q <= '0;
            tickDue_q <= 1'b0;
            skip_q    <= 1'b0;
            cpuEn_q   <= 1'b0;
        end else begin
            cpuEn_q   <= 1'b0;
            tickDue_q <= 1'b0;
            case (state_q)
                RC_HALT: begin
                    if (runRise_q) begin
                        state_q   <= RC_RUN;
                        divider_q <= reloadMinus1;
                    end else if (stepPress) begin
                        state_q <= RC_STEP;
                    end
                end
                RC_STEP: begin
                    cpuEn_q <= 1'b1;
                    skip_q  <= 1'b0;
                    state_q <= RC_HALT;
                end
                RC_RUN: begin
                    if (runFall_q) begin
                        state_q <= RC_HALT;
                    end else begin
                        if (divider_q == 32'd0) begin
                            divider_q <= reloadMinus1;
                            tickDue_q <= 1'b1;
                        end else begin
                            divider_q <= divider_q - 32'd1;
                        end
                        if (tickDue_q) begin
                            if (bpHit) begin
                                state_q <= RC_BREAK;
                            end else begin
                                cpuEn_q <= 1'b1;
                                skip_q  <= 1'b0;
                            end
                        end
                    end
                end
                RC_BREAK: begin
                    if (runFall_q) begin
                        state_q <= RC_HALT;
                    end else if (runRise_q) begin
                        state_q   <= RC_RUN;
                        divider_q <= reloadMinus1;
                        skip_q    <= 1'b1;
                    end else if (stepPress) begin
                        state_q <= RC_STEP;
                        skip_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= RC_HALT;
                end
            endcase
        end
    end

    // Count every cycle in which cpu_en is high; wraps naturally at 16 bits
    always_ff @(posedge clock) begin
        if (reset) begin
            tickCount_q <= '0;
        end else if (cpuEn_q) begin
            tickCount_q <= tickCount_q + 16'd1;
        end
    end

    assign cpu_en     = cpuEn_q;
    assign state      = state_q;
    assign halted     = (state_q == RC_HALT) || (state_q == RC_BREAK);
    assign at_break   = (state_q == RC_BREAK);
    assign tick_count = tickCount_q;

endmodule
